// File: rtl/risc_pkg.sv
// risc_pkg: opcodes, state codes and datapath select encodings shared by the
// multicycle controller and its decoder.
package risc_pkg;
    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;
    localparam logic [3:0] OP_ADD  = 4'h0, OP_ADI  = 4'h1, OP_NAND = 4'h2, OP_LHI  = 4'h3,
                           OP_LW   = 4'h4, OP_SW   = 4'h5, OP_LM   = 4'h6, OP_SM   = 4'h7,
                           OP_JAL  = 4'h8, OP_JLR  = 4'h9, OP_BEQ  = 4'hC, OP_RSVD = 4'hD,
                           OP_RSVE = 4'hE, OP_RSVF = 4'hF;
    localparam logic [1:0] CC_Z = 2'b01, CC_C = 2'b10, CC_BAD = 2'b11;
    localparam logic [1:0] PC_INC = 2'd0, PC_IMM6 = 2'd1, PC_IMM9 = 2'd2, PC_REG = 2'd3;
    localparam logic [1:0] FC_NONE = 2'd0, FC_ILLEGAL = 2'd1, FC_TIMEOUT = 2'd2;
    localparam logic [1:0] ALU_A_PC = 2'd0, ALU_A_RA = 2'd1, ALU_A_RB = 2'd2;
    localparam logic [2:0] ALU_B_RB = 3'd0, ALU_B_IMM6 = 3'd1, ALU_B_ONE = 3'd2;
    localparam logic [1:0] WA_RC = 2'd0, WA_RB = 2'd1, WA_RA = 2'd2;
    localparam logic [2:0] WD_ALU = 3'd0, WD_MEM = 3'd1, WD_LHI = 3'd2, WD_PC1 = 3'd3;
endpackage

// File: rtl/risc_decode.sv
// risc_decode: opcode-class decode of the latched opcode and condition field.
module risc_decode import risc_pkg::*; #(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op_i,
    input  logic [1:0]     cc_i,
    output logic           is_mem_o,
    output logic           is_branch_o,
    output logic           is_cond_o,
    output logic           is_legal_o,
    output logic           writes_flags_o
);
    always_comb begin
        is_mem_o       = op_i == OPW'(OP_LW) || op_i == OPW'(OP_SW);
        is_branch_o    = op_i == OPW'(OP_BEQ);
        is_cond_o      = op_i == OPW'(OP_ADD) || op_i == OPW'(OP_NAND);
        writes_flags_o = is_cond_o || op_i == OPW'(OP_ADI);
        is_legal_o     = !(op_i inside {OPW'(OP_LM), OPW'(OP_SM), OPW'(OP_RSVD), OPW'(OP_RSVE), OPW'(OP_RSVF)})
                         && !(is_cond_o && cc_i == CC_BAD);
    end
endmodule

// File: rtl/risc_mc_ctrl.sv
// risc_mc_ctrl: multicycle controller sequencing fetch, decode, execute,
// memory and writeback, with illegal-opcode and memory-timeout halting.
module risc_mc_ctrl import risc_pkg::*; #(
    parameter int DW          = 16,
    parameter int OPW         = 4,
    parameter int CNTW        = 32,
    parameter int MEMWAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   instr,
    input  logic            mem_ready,
    input  logic            eq,
    input  logic            flag_c,
    input  logic            flag_z,
    output logic            ir_en,
    output logic            pc_en,
    output logic [1:0]      pc_sel,
    output logic            alu_op,
    output logic [1:0]      alu_a_sel,
    output logic [2:0]      alu_b_sel,
    output logic            reg_we,
    output logic [1:0]      wr_addr_sel,
    output logic [2:0]      wr_data_sel,
    output logic            mem_req,
    output logic            mem_we,
    output logic            addr_sel,
    output logic            flag_en,
    output logic            retire,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [CNTW-1:0] icount,
    output logic [2:0]      state
);
    localparam int WW = $clog2(MEMWAIT_MAX + 1);
    state_t          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [1:0]      cc_q, cc_d, fc_q, fc_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [CNTW-1:0] icount_q;
    logic            is_mem, is_branch, is_cond, is_legal, writes_flags;
    logic            is_sw, is_jal, is_jlr, cond_fail, waiting, timeout;
    logic            unused_instr;

    assign unused_instr = ^instr[DW-OPW-1:2];

    risc_decode #(.OPW(OPW)) u_decode (
        .op_i           (op_q),
        .cc_i           (cc_q),
        .is_mem_o       (is_mem),
        .is_branch_o    (is_branch),
        .is_cond_o      (is_cond),
        .is_legal_o     (is_legal),
        .writes_flags_o (writes_flags)
    );

    assign is_sw     = op_q == OPW'(OP_SW);
    assign is_jal    = op_q == OPW'(OP_JAL);
    assign is_jlr    = op_q == OPW'(OP_JLR);
    // conditional ALU ops drop their register write when the tested flag is clear
    assign cond_fail = is_cond && ((cc_q == CC_C && !flag_c) || (cc_q == CC_Z && !flag_z));
    assign waiting   = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    assign timeout   = wait_q == WW'(MEMWAIT_MAX - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RESET;
            op_q     <= '0;
            cc_q     <= '0;
            fc_q     <= FC_NONE;
            wait_q   <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cc_q     <= cc_d;
            fc_q     <= fc_d;
            wait_q   <= wait_d;
            icount_q <= icount_q + CNTW'(retire);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cc_d     = cc_q;
        fc_d     = fc_q;
        wait_d   = waiting ? wait_q + WW'(1) : '0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_INC;
        reg_we   = 1'b0;
        flag_en  = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_en   = mem_ready;
                if (mem_ready) begin
                    op_d    = instr[DW-1 -: OPW];
                    cc_d    = instr[1:0];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_legal ? S_EXEC : S_HALT;
                fc_d    = is_legal ? fc_q : FC_ILLEGAL;
            end
            S_EXEC: begin
                state_d = is_mem ? S_MEM : is_branch ? S_FETCH : S_WB;
                pc_en   = is_branch;
                pc_sel  = is_branch && eq ? PC_IMM6 : PC_INC;
                retire  = is_branch;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                retire   = is_sw && mem_ready;
                pc_en    = is_sw && mem_ready;
                if (mem_ready) state_d = is_sw ? S_FETCH : S_WB;
            end
            S_WB: begin
                reg_we  = !cond_fail;
                flag_en = writes_flags;
                pc_en   = 1'b1;
                pc_sel  = is_jal ? PC_IMM9 : is_jlr ? PC_REG : PC_INC;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: ;
        endcase
        if (waiting && timeout) begin
            state_d = S_HALT;
            fc_d    = FC_TIMEOUT;
        end
    end

    always_comb begin
        alu_op      = !(state_q == S_EXEC && op_q == OPW'(OP_NAND));
        alu_a_sel   = state_q != S_EXEC ? ALU_A_PC : is_mem ? ALU_A_RB : ALU_A_RA;
        alu_b_sel   = state_q != S_EXEC ? ALU_B_ONE : (is_mem || op_q == OPW'(OP_ADI)) ? ALU_B_IMM6 : ALU_B_RB;
        wr_addr_sel = is_cond ? WA_RC : op_q == OPW'(OP_ADI) ? WA_RB : WA_RA;
        wr_data_sel = op_q == OPW'(OP_LW) ? WD_MEM : op_q == OPW'(OP_LHI) ? WD_LHI : (is_jal || is_jlr) ? WD_PC1 : WD_ALU;
    end

    assign fault      = state_q == S_HALT;
    assign fault_code = fc_q;
    assign icount     = icount_q;
    assign state      = state_q;
endmodule

// File: tb/tb_risc_mc_ctrl.sv
// tb_risc_mc_ctrl: randomized instruction stream checked cycle by cycle against
// an expected trace built from the per-opcode sequencing rules.
module tb_risc_mc_ctrl;
    localparam int DW = 16, CNTW = 4, MAXW = 15;

    typedef struct packed {
        logic [2:0] st;
        logic       ir, pce;
        logic [1:0] pcs;
        logic       rwe, fen, mreq, mwe, asel, ret, aop, flt;
        logic [1:0] fc;
    } cyc_t;

    typedef struct {
        cyc_t          e;
        int            mr;
        logic [DW-1:0] ins;
        bit            eq, fc, fz;
    } item_t;

    logic clk = 1'b0;
    logic rst, mem_ready, eq, flag_c, flag_z;
    logic [DW-1:0] instr;
    logic ir_en, pc_en, alu_op, reg_we, mem_req, mem_we, addr_sel, flag_en, retire, fault;
    logic [1:0] pc_sel, alu_a_sel, wr_addr_sel, fault_code;
    logic [2:0] alu_b_sel, wr_data_sel, state;
    logic [CNTW-1:0] icount, exp_cnt;
    logic [1:0] exp_fc;
    logic [DW-1:0] cur_ins;
    bit cur_eq, cur_fc, cur_fz;
    item_t q[$];
    int checks = 0, failures = 0;
    int legal[11] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12};

    risc_mc_ctrl #(.DW(DW), .OPW(4), .CNTW(CNTW), .MEMWAIT_MAX(MAXW)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .eq(eq),
        .flag_c(flag_c), .flag_z(flag_z), .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel),
        .alu_op(alu_op), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .reg_we(reg_we),
        .wr_addr_sel(wr_addr_sel), .wr_data_sel(wr_data_sel), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .flag_en(flag_en), .retire(retire),
        .fault(fault), .fault_code(fault_code), .icount(icount), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t obs();
        cyc_t o;
        o.st = state; o.ir = ir_en; o.pce = pc_en; o.pcs = pc_en ? pc_sel : 2'd0;
        o.rwe = reg_we; o.fen = flag_en; o.mreq = mem_req; o.mwe = mem_we;
        o.asel = addr_sel; o.ret = retire; o.aop = alu_op; o.flt = fault; o.fc = fault_code;
        return o;
    endfunction

    function automatic cyc_t c(input logic [2:0] st);
        cyc_t x = '0;
        x.st = st; x.aop = 1'b1; x.flt = (st == 3'd6); x.fc = (st == 3'd6) ? exp_fc : 2'd0;
        return x;
    endfunction

    task automatic push(input cyc_t e, input int mr);
        item_t it;
        it.e = e; it.mr = mr; it.ins = cur_ins; it.eq = cur_eq; it.fc = cur_fc; it.fz = cur_fz;
        q.push_back(it);
    endtask

    // mr: 0/1 forces mem_ready, 2 drives a random (ignored) value
    task automatic build(input int op, input logic [1:0] cc, input bit e, input bit fc, input bit fz,
                         input int kf, input int km, output bit halted);
        cyc_t x;
        bit alu = (op == 0 || op == 2);
        bit sw = (op == 5);
        halted = 1'b0;
        cur_ins = {4'(op), 10'($urandom), cc};
        cur_eq = e; cur_fc = fc; cur_fz = fz;
        x = c(3'd1); x.mreq = 1'b1;
        for (int i = 0; i < kf && i < MAXW; i++) push(x, 0);
        if (kf >= MAXW) begin exp_fc = 2'd2; push(c(3'd6), 2); halted = 1'b1; return; end
        x.ir = 1'b1; push(x, 1);
        push(c(3'd2), 2);
        if (op inside {6, 7, 13, 14, 15} || (alu && cc == 2'b11)) begin
            exp_fc = 2'd1; push(c(3'd6), 2); halted = 1'b1; return;
        end
        x = c(3'd3); x.aop = (op != 2);
        if (op == 12) begin x.pce = 1'b1; x.pcs = e ? 2'd1 : 2'd0; x.ret = 1'b1; end
        push(x, 2);
        if (op == 12) return;
        if (op == 4 || sw) begin
            x = c(3'd4); x.mreq = 1'b1; x.asel = 1'b1; x.mwe = sw;
            for (int i = 0; i < km && i < MAXW; i++) push(x, 0);
            if (km >= MAXW) begin exp_fc = 2'd2; push(c(3'd6), 2); halted = 1'b1; return; end
            x.ret = sw; x.pce = sw; push(x, 1);
            if (sw) return;
        end
        x = c(3'd5);
        x.rwe = !(alu && ((cc == 2'b10 && !fc) || (cc == 2'b01 && !fz)));
        x.fen = (op <= 2); x.pce = 1'b1; x.ret = 1'b1;
        x.pcs = op == 8 ? 2'd2 : op == 9 ? 2'd3 : 2'd0;
        push(x, 2);
    endtask

    task automatic play();
        item_t it;
        while (q.size() > 0) begin
            it = q.pop_front();
            @(negedge clk);
            mem_ready = (it.mr == 2) ? 1'($urandom) : 1'(it.mr);
            instr = it.e.ir ? it.ins : DW'($urandom);
            eq = it.eq; flag_c = it.fc; flag_z = it.fz;
            #1;
            check("cycle", 32'(obs()), 32'(it.e));
            check("icount", 32'(icount), 32'(exp_cnt));
            exp_cnt = exp_cnt + CNTW'(it.e.ret);
        end
    endtask

    task automatic halt_hold();
        repeat (3) push(c(3'd6), 2);
        play();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        exp_fc = 2'd0; exp_cnt = '0;
        check("rst_async", 32'(obs()), 32'(c(3'd0)));
        check("rst_icount", 32'(icount), 32'(exp_cnt));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release", 32'(obs()), 32'(c(3'd0)));
    endtask

    function automatic int pick_wait();
        int r = int'($urandom_range(0, 19));
        return r < 16 ? r % 4 : r < 18 ? 14 : 15;
    endfunction

    initial begin
        bit h;
        rst = 1'b1; mem_ready = 1'b0; instr = '0; eq = 1'b0; flag_c = 1'b0; flag_z = 1'b0;
        exp_cnt = '0; exp_fc = '0; cur_ins = '0;
        repeat (2) @(negedge clk);
        do_reset();
        build(0, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, h);  play();
        build(5, 2'b00, 1'b0, 1'b0, 1'b0, 0, 3, h);  play();
        build(12, 2'b00, 1'b1, 1'b0, 1'b0, 0, 0, h); play();
        build(0, 2'b10, 1'b0, 1'b0, 1'b1, 0, 0, h);  play();
        build(2, 2'b01, 1'b0, 1'b1, 1'b0, 1, 0, h);  play();
        build(4, 2'b00, 1'b0, 1'b0, 1'b0, 2, 14, h); play();
        build(8, 2'b00, 1'b0, 1'b0, 1'b0, 14, 0, h); play();
        build(15, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, h); play(); halt_hold(); do_reset();
        build(0, 2'b00, 1'b0, 1'b0, 1'b0, 15, 0, h); play(); halt_hold(); do_reset();
        build(1, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, h);  play();
        build(5, 2'b00, 1'b0, 1'b0, 1'b0, 0, 3, h);
        void'(q.pop_back());
        play();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("mem_we_held", 32'(mem_we), 32'd1);
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int op, kf, km;
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : legal[$urandom_range(0, 10)];
            kf = pick_wait();
            km = pick_wait();
            build(op, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), kf, km, h);
            play();
            if (h) begin
                halt_hold();
                do_reset();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
